// File: rtl/rename_cap_stage.sv
// Rename stage: classifies capability micro-ops, meters them against a retire-fed credit pool,
// and buffers one bundle toward dispatch. Optional statistics counters: RENAME_CAP_STATS_EN.
`timescale 1ns/1ps

package uop_pkg;
  typedef enum logic [4:0] {
    UOP_NOP                = 5'd0,
    UOP_INT_ALU            = 5'd1,
    UOP_INT_MUL            = 5'd2,
    UOP_LOAD               = 5'd3,
    UOP_STORE              = 5'd4,
    UOP_BRANCH             = 5'd5,
    UOP_PREFIX_SELECT      = 5'd6,
    UOP_PREFIX_CANCEL      = 5'd7,
    UOP_CAP_CLONE_RESTRICT = 5'd8,
    UOP_CAP_LOAN_BEGIN     = 5'd9,
    UOP_CAP_LOAN_END       = 5'd10,
    UOP_CAP_JUMP           = 5'd11,
    UOP_CAP_RET            = 5'd12,
    UOP_LINK               = 5'd13
  } uop_tag_t;
endpackage

module rename_cap_stage #(
  parameter int LANES       = 4,
  parameter int CAP_CREDITS = 8,
  parameter int CNT_W       = 16,
  localparam int CW = $clog2(LANES + 1),
  localparam int KW = $clog2(CAP_CREDITS + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             decode_valid_i,
  output logic                             decode_ready_o,
  input  uop_pkg::uop_tag_t [LANES-1:0]    decode_uops_i,
  input  logic [CW-1:0]                    decode_uop_count_i,
  output logic                             dispatch_valid_o,
  input  logic                             dispatch_ready_i,
  output uop_pkg::uop_tag_t [LANES-1:0]    dispatch_uops_o,
  output logic [CW-1:0]                    dispatch_uop_count_o,
  output logic [LANES-1:0]                 dispatch_cap_mask_o,
  input  logic                             cap_retire_valid_i,
  input  logic [CW-1:0]                    cap_retire_count_i,
  output logic [KW-1:0]                    cap_credits_o,
  output logic                             cap_stall_o,
  output logic [CNT_W-1:0]                 capability_issued_count_o,
  output logic [CNT_W-1:0]                 cap_stall_cycles_o
);

  // Sum width wide enough that credits plus any retire count never wraps.
  localparam int SW = ((KW > CW) ? KW : CW) + 1;

  if (CAP_CREDITS < LANES) begin : g_bad_credits
    $error("rename_cap_stage: CAP_CREDITS must be >= LANES");
  end

  function automatic logic is_cap(input uop_pkg::uop_tag_t t);
    case (t)
      uop_pkg::UOP_PREFIX_SELECT, uop_pkg::UOP_PREFIX_CANCEL,
      uop_pkg::UOP_CAP_CLONE_RESTRICT, uop_pkg::UOP_CAP_LOAN_BEGIN,
      uop_pkg::UOP_CAP_LOAN_END, uop_pkg::UOP_CAP_JUMP,
      uop_pkg::UOP_CAP_RET, uop_pkg::UOP_LINK: is_cap = 1'b1;
      default:                                 is_cap = 1'b0;
    endcase
  endfunction

  logic                            valid_q, valid_d;
  uop_pkg::uop_tag_t [LANES-1:0]   uops_q, uops_d;
  logic [CW-1:0]                   count_q, count_d;
  logic [LANES-1:0]                mask_q, mask_d;
  logic [KW-1:0]                   credits_q, credits_d;

  logic [CW-1:0]    n_eff;
  logic [LANES-1:0] cap_mask;
  logic [CW-1:0]    need;
  logic             slot_free, credit_ok, accept;
  logic [SW-1:0]    credit_sum;

  always_comb begin
    n_eff    = (decode_uop_count_i > CW'(LANES)) ? CW'(LANES) : decode_uop_count_i;
    cap_mask = '0;
    need     = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((CW'(i) < n_eff) && is_cap(decode_uops_i[i])) begin
        cap_mask[i] = 1'b1;
        need        = need + CW'(1);
      end
    end

    slot_free      = !valid_q || dispatch_ready_i;
    credit_ok      = SW'(need) <= SW'(credits_q);
    decode_ready_o = slot_free && credit_ok;
    accept         = decode_valid_i && decode_ready_o;
    cap_stall_o    = decode_valid_i && slot_free && !credit_ok;

    // accept guarantees need <= credits_q, so the subtraction cannot underflow.
    credit_sum = SW'(credits_q)
               - (accept ? SW'(need) : SW'(0))
               + (cap_retire_valid_i ? SW'(cap_retire_count_i) : SW'(0));
    credits_d  = (credit_sum > SW'(CAP_CREDITS)) ? KW'(CAP_CREDITS) : credit_sum[KW-1:0];

    valid_d = valid_q;
    uops_d  = uops_q;
    count_d = count_q;
    mask_d  = mask_q;
    if (accept && (n_eff != '0)) begin
      valid_d = 1'b1;
      uops_d  = decode_uops_i;
      count_d = n_eff;
      mask_d  = cap_mask;
    end else if (dispatch_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      count_q   <= '0;
      mask_q    <= '0;
      credits_q <= KW'(CAP_CREDITS);
      for (int i = 0; i < LANES; i++) uops_q[i] <= uop_pkg::UOP_NOP;
    end else begin
      valid_q   <= valid_d;
      uops_q    <= uops_d;
      count_q   <= count_d;
      mask_q    <= mask_d;
      credits_q <= credits_d;
    end
  end

  assign dispatch_valid_o     = valid_q;
  assign dispatch_uops_o      = uops_q;
  assign dispatch_uop_count_o = count_q;
  assign dispatch_cap_mask_o  = mask_q;
  assign cap_credits_o        = credits_q;

`ifdef RENAME_CAP_STATS_EN
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Issued count wraps; stall-cycle count saturates.
  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (accept)                       issued_d = issued_q + CNT_W'(need);
    if (cap_stall_o && (stall_q != '1)) stall_d  = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign capability_issued_count_o = issued_q;
  assign cap_stall_cycles_o        = stall_q;
`else
  assign capability_issued_count_o = '0;
  assign cap_stall_cycles_o        = '0;
`endif

endmodule
